// File: rtl/chess_pkg.sv
// Shared types and helpers for the chess board selection logic.
package chess_pkg;

  // Selection controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    COMMIT   = 2'd2
  } sel_state_t;

  // Widest row/col index the helper supports (BOARD_N up to 16).
  localparam int MAX_IDX_W = 4;

  // Square index from {row,col}: row * BOARD_N + col with BOARD_N = 2**idx_w.
  function automatic int unsigned sq_index(
    input logic [MAX_IDX_W-1:0] row,
    input logic [MAX_IDX_W-1:0] col,
    input int unsigned          idx_w
  );
    int unsigned idx_v;
    idx_v = (int'(row) << idx_w) | int'(col);
    return idx_v;
  endfunction

endpackage

// File: rtl/board_square_decode.sv
// Combinational pixel-to-square decoder. Shared with the highlight renderer,
// so it carries no state: callers register the outputs as they need.
module board_square_decode #(
  parameter int BOARD_N  = 8,
  parameter int SQ_LOG2  = 6,
  parameter int ORIGIN_X = 256,
  parameter int ORIGIN_Y = 128,
  parameter int COORD_W  = 12,
  parameter int IDX_W    = $clog2(BOARD_N)
) (
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic [IDX_W-1:0]   row,
  output logic [IDX_W-1:0]   col,
  output logic               valid
);

  // Offsets are COORD_W+1 bits wide; the top bit is the sign of the offset.
  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] ORG_X = CW1'(ORIGIN_X);
  localparam logic [COORD_W:0] ORG_Y = CW1'(ORIGIN_Y);
  localparam logic [COORD_W:0] LIMIT = CW1'(BOARD_N);

  logic [COORD_W:0] dx_s;
  logic [COORD_W:0] dy_s;
  logic [COORD_W:0] col_wide_s;
  logic [COORD_W:0] row_wide_s;

  // Offset from board origin, divide by square edge, and range-check.
  always_comb begin
    dx_s       = {1'b0, xpos} - ORG_X;
    dy_s       = {1'b0, ypos} - ORG_Y;
    col_wide_s = dx_s >> SQ_LOG2;
    row_wide_s = dy_s >> SQ_LOG2;
    // A negative offset means left of / above the board; the shifted value
    // is then meaningless, so the sign test gates the range test.
    valid = !dx_s[COORD_W] && !dy_s[COORD_W] &&
            (col_wide_s < LIMIT) && (row_wide_s < LIMIT);
    col   = col_wide_s[IDX_W-1:0];
    row   = row_wide_s[IDX_W-1:0];
  end

endmodule

// File: rtl/board_select_fsm.sv
// Cursor-to-square tracking and two-click pick/place controller. Offers the
// completed move over a valid/ready handshake and owns the side-to-move bit.
module board_select_fsm
  import chess_pkg::*;
#(
  parameter int BOARD_N  = 8,
  parameter int SQ_LOG2  = 6,
  parameter int ORIGIN_X = 256,
  parameter int ORIGIN_Y = 128,
  parameter int COORD_W  = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             mouse_xpos,
  input  logic [COORD_W-1:0]             mouse_ypos,
  input  logic                           mouse_left,
  input  logic                           mouse_right,
  input  logic [BOARD_N*BOARD_N-1:0]     own_piece,
  input  logic [BOARD_N*BOARD_N-1:0]     possible_moves,
  output logic [2*$clog2(BOARD_N)-1:0]   cursor_sq,
  output logic                           cursor_valid,
  output logic [2*$clog2(BOARD_N)-1:0]   sel_sq,
  output logic                           sel_valid,
  output logic                           move_valid,
  output logic [2*$clog2(BOARD_N)-1:0]   move_from,
  output logic [2*$clog2(BOARD_N)-1:0]   move_to,
  input  logic                           move_ready,
  output logic                           side_to_move
);

  localparam int IDX_W = $clog2(BOARD_N);
  localparam int SQ_W  = 2 * IDX_W;

  // Decoder outputs for the live mouse position.
  logic [IDX_W-1:0] dec_row_s;
  logic [IDX_W-1:0] dec_col_s;
  logic             dec_valid_s;
  logic [SQ_W-1:0]  dec_sq_s;

  // Registered state.
  sel_state_t       state_r;
  logic [SQ_W-1:0]  cursor_sq_r;
  logic             cursor_valid_r;
  logic [SQ_W-1:0]  sel_sq_r;
  logic             sel_valid_r;
  logic             move_valid_r;
  logic [SQ_W-1:0]  move_from_r;
  logic [SQ_W-1:0]  move_to_r;
  logic             side_r;
  logic             left_prev_r;
  logic             right_prev_r;
  logic             hist_armed_r;

  // Click strobes and square lookups for the FSM.
  logic             left_click_s;
  logic             right_click_s;
  logic             own_hit_s;
  logic             legal_hit_s;
  logic             same_sq_s;

  board_square_decode #(
    .BOARD_N  (BOARD_N),
    .SQ_LOG2  (SQ_LOG2),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .COORD_W  (COORD_W),
    .IDX_W    (IDX_W)
  ) u_decode (
    .xpos  (mouse_xpos),
    .ypos  (mouse_ypos),
    .row   (dec_row_s),
    .col   (dec_col_s),
    .valid (dec_valid_s)
  );

  // Flatten the decoded {row,col} into the square index.
  always_comb begin
    dec_sq_s = SQ_W'(sq_index(MAX_IDX_W'(dec_row_s), MAX_IDX_W'(dec_col_s), IDX_W));
  end

  // Rising-edge detection on the frame-sampled button levels. The first
  // frame after reset only primes the history, so a button held through
  // reset cannot produce a click.
  always_comb begin
    if (frame_tick && hist_armed_r) begin
      left_click_s  = mouse_left && !left_prev_r;
      right_click_s = mouse_right && !right_prev_r;
    end else begin
      left_click_s  = 1'b0;
      right_click_s = 1'b0;
    end
  end

  // Look up the previous frame's cursor square in the board masks.
  always_comb begin
    own_hit_s   = own_piece[cursor_sq_r];
    legal_hit_s = possible_moves[cursor_sq_r];
    same_sq_s   = (cursor_sq_r == sel_sq_r);
  end

  // Once per frame: capture the cursor square and the button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_sq_r    <= {SQ_W{1'b0}};
      cursor_valid_r <= 1'b0;
      left_prev_r    <= 1'b0;
      right_prev_r   <= 1'b0;
      hist_armed_r   <= 1'b0;
    end else if (frame_tick) begin
      cursor_valid_r <= dec_valid_s;
      if (dec_valid_s) begin
        cursor_sq_r <= dec_sq_s;
      end
      left_prev_r  <= mouse_left;
      right_prev_r <= mouse_right;
      hist_armed_r <= 1'b1;
    end
  end

  // Selection controller with its registered outputs. Clicks only exist on
  // frame_tick cycles; the handshake in COMMIT is evaluated every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sel_sq_r     <= {SQ_W{1'b0}};
      sel_valid_r  <= 1'b0;
      move_valid_r <= 1'b0;
      move_from_r  <= {SQ_W{1'b0}};
      move_to_r    <= {SQ_W{1'b0}};
      side_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A simultaneous right click suppresses the selection.
          if (left_click_s && !right_click_s && cursor_valid_r && own_hit_s) begin
            sel_sq_r    <= cursor_sq_r;
            sel_valid_r <= 1'b1;
            state_r     <= SELECTED;
          end
        end
        SELECTED: begin
          if (right_click_s) begin
            sel_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else if (left_click_s) begin
            if (!cursor_valid_r || same_sq_s) begin
              sel_valid_r <= 1'b0;
              state_r     <= IDLE;
            end else if (own_hit_s) begin
              sel_sq_r <= cursor_sq_r;
            end else if (legal_hit_s) begin
              move_from_r  <= sel_sq_r;
              move_to_r    <= cursor_sq_r;
              move_valid_r <= 1'b1;
              state_r      <= COMMIT;
            end else begin
              sel_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end
        end
        COMMIT: begin
          if (move_ready) begin
            move_valid_r <= 1'b0;
            sel_valid_r  <= 1'b0;
            side_r       <= ~side_r;
            state_r      <= IDLE;
          end
        end
        default: begin
          sel_valid_r  <= 1'b0;
          move_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign cursor_sq    = cursor_sq_r;
  assign cursor_valid = cursor_valid_r;
  assign sel_sq       = sel_sq_r;
  assign sel_valid    = sel_valid_r;
  assign move_valid   = move_valid_r;
  assign move_from    = move_from_r;
  assign move_to      = move_to_r;
  assign side_to_move = side_r;

endmodule

// File: tb/tb_board_select_fsm.sv
// Self-checking bench for board_select_fsm: directed scenarios plus a
// randomized phase, all checked against a square-level behavioural model.
module tb_board_select_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] mouse_xpos = 12'd0;
  logic [11:0] mouse_ypos = 12'd0;
  logic        mouse_left = 1'b0;
  logic        mouse_right = 1'b0;
  logic [63:0] own_piece = 64'd0;
  logic [63:0] possible_moves = 64'd0;
  logic        move_ready = 1'b0;
  logic [5:0]  cursor_sq;
  logic        cursor_valid;
  logic [5:0]  sel_sq;
  logic        sel_valid;
  logic        move_valid;
  logic [5:0]  move_from;
  logic [5:0]  move_to;
  logic        side_to_move;

  board_select_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .mouse_xpos     (mouse_xpos),
    .mouse_ypos     (mouse_ypos),
    .mouse_left     (mouse_left),
    .mouse_right    (mouse_right),
    .own_piece      (own_piece),
    .possible_moves (possible_moves),
    .cursor_sq      (cursor_sq),
    .cursor_valid   (cursor_valid),
    .sel_sq         (sel_sq),
    .sel_valid      (sel_valid),
    .move_valid     (move_valid),
    .move_from      (move_from),
    .move_to        (move_to),
    .move_ready     (move_ready),
    .side_to_move   (side_to_move)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  // Count accepted moves.
  always @(posedge clk) begin
    if (rst_n && move_valid && move_ready) n_xfer <= n_xfer + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (square level) ----------------
  int m_cur_sq, m_cur_ok, m_sel, m_selected, m_offer, m_from, m_to, m_side;
  int m_lprev, m_rprev, m_armed;

  function automatic void model_reset();
    m_cur_sq = 0; m_cur_ok = 0; m_sel = 0; m_selected = 0; m_offer = 0;
    m_from = 0; m_to = 0; m_side = 0; m_lprev = 0; m_rprev = 0; m_armed = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    int dx, dy, lc, rc;
    if (m_offer != 0) begin
      if (move_ready) begin
        m_offer = 0; m_selected = 0; m_side = 1 - m_side;
      end
    end else if (frame_tick) begin
      lc = (m_armed != 0 && mouse_left && m_lprev == 0) ? 1 : 0;
      rc = (m_armed != 0 && mouse_right && m_rprev == 0) ? 1 : 0;
      if (m_selected != 0) begin
        if (rc != 0) m_selected = 0;
        else if (lc != 0) begin
          if (m_cur_ok == 0 || m_cur_sq == m_sel) m_selected = 0;
          else if (own_piece[m_cur_sq]) m_sel = m_cur_sq;
          else if (possible_moves[m_cur_sq]) begin
            m_offer = 1; m_from = m_sel; m_to = m_cur_sq;
          end else m_selected = 0;
        end
      end else if (lc != 0 && rc == 0 && m_cur_ok != 0 && own_piece[m_cur_sq]) begin
        m_selected = 1; m_sel = m_cur_sq;
      end
    end
    if (frame_tick) begin
      dx = int'(mouse_xpos) - 256;
      dy = int'(mouse_ypos) - 128;
      if (dx >= 0 && dy >= 0 && dx / 64 < 8 && dy / 64 < 8) begin
        m_cur_ok = 1; m_cur_sq = (dy / 64) * 8 + dx / 64;
      end else m_cur_ok = 0;
      m_lprev = mouse_left ? 1 : 0;
      m_rprev = mouse_right ? 1 : 0;
      m_armed = 1;
    end
  endfunction

  task automatic compare_all();
    check_eq("cursor_sq", int'(cursor_sq), m_cur_sq);
    check_eq("cursor_valid", int'(cursor_valid), m_cur_ok);
    check_eq("sel_sq", int'(sel_sq), m_sel);
    check_eq("sel_valid", int'(sel_valid), m_selected);
    check_eq("move_valid", int'(move_valid), m_offer);
    check_eq("move_from", int'(move_from), m_from);
    check_eq("move_to", int'(move_to), m_to);
    check_eq("side_to_move", int'(side_to_move), m_side);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic int sqx(int sq); return 256 + (sq % 8) * 64 + 17; endfunction
  function automatic int sqy(int sq); return 128 + (sq / 8) * 64 + 40; endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic frame(input int x, input int y, input bit l, input bit r);
    mouse_xpos = 12'(x); mouse_ypos = 12'(y);
    mouse_left = l; mouse_right = r;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (3) cyc();
  endtask

  // Park on a square for a frame, click there, then release.
  task automatic click_sq(input int sq, input bit l, input bit r);
    frame(sqx(sq), sqy(sq), 1'b0, 1'b0);
    frame(sqx(sq), sqy(sq), l, r);
    frame(sqx(sq), sqy(sq), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    model_reset();
    #12;
    check_eq("reset_cursor_valid", int'(cursor_valid), 0);
    check_eq("reset_sel_valid", int'(sel_valid), 0);
    check_eq("reset_move_valid", int'(move_valid), 0);
    check_eq("reset_side", int'(side_to_move), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cursor decode.
    frame(300, 140, 1'b0, 1'b0);
    check_eq("cur_a_sq", int'(cursor_sq), 0);
    check_eq("cur_a_valid", int'(cursor_valid), 1);
    frame(700, 600, 1'b0, 1'b0);
    check_eq("cur_b_sq", int'(cursor_sq), 62);
    check_eq("cur_b_valid", int'(cursor_valid), 1);
    frame(255, 200, 1'b0, 1'b0);
    check_eq("cur_off_valid", int'(cursor_valid), 0);
    check_eq("cur_off_sq_hold", int'(cursor_sq), 62);
    frame(767, 639, 1'b0, 1'b0);
    check_eq("cur_corner_sq", int'(cursor_sq), 63);
    frame(768, 639, 1'b0, 1'b0);
    check_eq("cur_right_edge_valid", int'(cursor_valid), 0);

    // Zero-wait move 52 -> 36.
    own_piece = 64'd0; own_piece[52] = 1'b1; own_piece[51] = 1'b1;
    possible_moves = 64'd0; possible_moves[36] = 1'b1;
    move_ready = 1'b1;
    click_sq(52, 1'b1, 1'b0);
    check_eq("sel_52_valid", int'(sel_valid), 1);
    check_eq("sel_52_sq", int'(sel_sq), 52);
    frame(sqx(36), sqy(36), 1'b0, 1'b0);
    base = n_xfer;
    mouse_left = 1'b1; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check_eq("mv_offer", int'(move_valid), 1);
    check_eq("mv_from", int'(move_from), 52);
    check_eq("mv_to", int'(move_to), 36);
    check_eq("mv_side_before", int'(side_to_move), 0);
    cyc();
    check_eq("mv_one_cycle", int'(move_valid), 0);
    check_eq("mv_side_after", int'(side_to_move), 1);
    check_eq("mv_idle_sel", int'(sel_valid), 0);
    check_eq("mv_xfer_count", n_xfer - base, 1);
    frame(sqx(36), sqy(36), 1'b0, 1'b0);

    // Right-click cancel, illegal destination, reselect, same-square.
    click_sq(52, 1'b1, 1'b0);
    click_sq(52, 1'b0, 1'b1);
    check_eq("cancel_sel", int'(sel_valid), 0);
    check_eq("cancel_no_move", int'(move_valid), 0);
    click_sq(52, 1'b1, 1'b0);
    click_sq(20, 1'b1, 1'b0);
    check_eq("illegal_sel", int'(sel_valid), 0);
    click_sq(52, 1'b1, 1'b0);
    click_sq(51, 1'b1, 1'b0);
    check_eq("reselect_sq", int'(sel_sq), 51);
    check_eq("reselect_valid", int'(sel_valid), 1);
    click_sq(51, 1'b1, 1'b0);
    check_eq("same_sq_desel", int'(sel_valid), 0);

    // Stalled commit: held offer, clicks ignored, one transfer.
    move_ready = 1'b0;
    click_sq(52, 1'b1, 1'b0);
    click_sq(36, 1'b1, 1'b0);
    repeat (5) cyc();
    click_sq(51, 1'b1, 1'b0);
    check_eq("stall_valid", int'(move_valid), 1);
    check_eq("stall_from", int'(move_from), 52);
    check_eq("stall_to", int'(move_to), 36);
    check_eq("stall_sel", int'(sel_valid), 1);
    base = n_xfer;
    move_ready = 1'b1;
    cyc();
    check_eq("stall_drop", int'(move_valid), 0);
    check_eq("stall_side", int'(side_to_move), 0);
    move_ready = 1'b0;
    repeat (3) cyc();
    check_eq("stall_xfer_count", n_xfer - base, 1);

    // Asynchronous reset in the middle of a commit, button held through it.
    click_sq(52, 1'b1, 1'b0);
    click_sq(36, 1'b1, 1'b0);
    check_eq("pre_rst_valid", int'(move_valid), 1);
    mouse_xpos = 12'(sqx(52)); mouse_ypos = 12'(sqy(52)); mouse_left = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_move_valid", int'(move_valid), 0);
    check_eq("rst_side", int'(side_to_move), 0);
    check_eq("rst_sel_valid", int'(sel_valid), 0);
    check_eq("rst_cursor_valid", int'(cursor_valid), 0);
    check_eq("rst_move_from", int'(move_from), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    frame(sqx(52), sqy(52), 1'b1, 1'b0);
    frame(sqx(52), sqy(52), 1'b1, 1'b0);
    check_eq("held_btn_no_sel", int'(sel_valid), 0);
    frame(sqx(52), sqy(52), 1'b0, 1'b0);

    // Randomized frames against the model.
    for (int f = 0; f < 400; f++) begin
      own_piece = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      possible_moves = {$urandom(), $urandom()} & ~own_piece;
      if ($urandom_range(0, 9) < 8) begin
        mouse_xpos = 12'(256 + $urandom_range(0, 511));
        mouse_ypos = 12'(128 + $urandom_range(0, 511));
      end else begin
        mouse_xpos = 12'($urandom_range(0, 1023));
        mouse_ypos = 12'($urandom_range(0, 1023));
      end
      mouse_left = 1'($urandom_range(0, 1));
      mouse_right = ($urandom_range(0, 4) == 0);
      move_ready = ($urandom_range(0, 2) == 0);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        mouse_xpos = 12'($urandom_range(0, 1023));
        mouse_left = 1'($urandom_range(0, 1));
        mouse_right = 1'($urandom_range(0, 1));
        move_ready = ($urandom_range(0, 2) == 0);
        cyc();
      end
      if (f == 200) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_select_fsm.md
# board_select_fsm

Parametrised cursor-to-square decoder and pick/place controller for the chess game logic. It converts the mouse pixel position into a board square once per frame and tracks a two-click move (select source, select destination). It issues the completed move to the move-apply logic through a valid/ready handshake and owns the side-to-move bit. It sits between the mouse controller / VGA timing and the board-state and move-generator blocks.

## Interface
Parameters:
- BOARD_N, 8, squares per side; power of two, 2..16
- SQ_LOG2, 6, log2 of square edge in pixels (64 px)
- ORIGIN_X, 256, pixel x of board's left edge
- ORIGIN_Y, 128, pixel y of board's top edge
- COORD_W, 12, mouse coordinate width
- derived: IDX_W = log2(BOARD_N), SQ_W = 2*IDX_W, NSQ = BOARD_N*BOARD_N

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle strobe at frame start (hcount==0 && vcount==0)
- mouse_xpos  in  COORD_W  cursor x, pixels
- mouse_ypos  in  COORD_W  cursor y, pixels
- mouse_left  in  1  left button level
- mouse_right  in  1  right button level; cancels a selection
- own_piece  in  NSQ  bit s = square s holds a piece of side_to_move
- possible_moves  in  NSQ  legal targets for the currently selected square
- cursor_sq  out  SQ_W  {row,col} under cursor
- cursor_valid  out  1  cursor inside board
- sel_sq  out  SQ_W  selected source square
- sel_valid  out  1  a source is selected (drives highlight / move generator)
- move_valid  out  1  move offered
- move_from  out  SQ_W  source of offered move
- move_to  out  SQ_W  destination of offered move
- move_ready  in  1  move-apply logic accepts
- side_to_move  out  1  0 = white, 1 = black

## Operation
- Decode: dx = mouse_xpos − ORIGIN_X, dy = mouse_ypos − ORIGIN_Y, both in COORD_W+1 bits signed. col = dx >> SQ_LOG2, row = dy >> SQ_LOG2. Inside only if dx, dy ≥ 0 and col, row < BOARD_N; otherwise cursor_valid=0 and cursor_sq holds its last value.
- Click = rising edge of mouse_left between consecutive frame_ticks; the button level is sampled only at frame_tick. A right press behaves the same way (rising edge at frame_tick).
- States (registered, enum):
  - IDLE: on click with cursor_valid && own_piece[cursor_sq], latch sel_sq and go to SELECTED.
  - SELECTED (sel_valid=1): right click → IDLE. Left click on another own piece → reselect, stay. Left click with possible_moves[cursor_sq] → latch move_to and go to COMMIT. Left click on the same square, an illegal square, or off-board → IDLE (deselect).
  - COMMIT (move_valid=1, sel_valid=1): wait for move_ready. On transfer, toggle side_to_move and go to IDLE. Clicks are ignored.
- When left and right clicks arrive in the same frame, right wins.
- move_from/move_to are stable while move_valid=1.

## Timing
- Reset values: state IDLE, cursor_sq 0, cursor_valid 0, sel_sq 0, sel_valid 0, move_valid 0, move_from 0, move_to 0, side_to_move 0, button history 0.
- cursor_sq and cursor_valid update in the cycle after frame_tick. FSM decisions at frame_tick use the previous frame's cursor, so the effective latency is one frame. This matches highlight rendering.
- IDLE/SELECTED transitions occur only on frame_tick cycles.
- COMMIT is evaluated every clk. Transfer happens on the edge where move_valid && move_ready. move_valid drops and side_to_move toggles on that same edge. move_ready asserted outside COMMIT is ignored.
- Zero-wait acceptance is allowed: move_valid can be high for exactly one cycle.
- rst_n asserted mid-COMMIT drops move_valid immediately (asynchronously); no move is issued and side_to_move returns to 0.
- Button held across reset does not generate a click on the first frame_tick after reset.

## Structure
- chess_pkg: sel_state_t enum {IDLE, SELECTED, COMMIT}, and a square-index helper function {row,col}→index.
- Sub-module board_square_decode: parametrised, combinational pixel→{row,col,valid}. It is reused by board-highlight rendering. The top level registers its outputs on frame_tick.

## Test plan
Defaults N=8, SQ_LOG2=6, origin (256,128):
- Mouse (300,140) then (700,600), with frame_tick: cursor_sq = 0 then 62 (row 7, col 6), cursor_valid = 1. Mouse (255,200): cursor_valid = 0, cursor_sq stays 62.
- own_piece[52]=1, click at sq 52; possible_moves[36]=1, click at sq 36, move_ready=1 → one-cycle move_valid, move_from=52, move_to=36, side_to_move 0→1, back to IDLE.
- Select 52, then right click → sel_valid=0, no move. Select 52, click illegal sq 20 → IDLE.
- Select 52, click own sq 51 → sel_sq=51, sel_valid stays 1.
- Enter COMMIT with move_ready=0 for 5 cycles: move_valid held, from/to stable, clicks ignored. Then ready=1 → single transfer.
- rst_n low during COMMIT → all outputs return to reset values immediately. Button held across reset → no selection on the next frame.
